// File: rtl/lc4_muldiv_pkg.sv
// Shared types and decode constants for the LC4 iterative multiply/divide unit.
// The op-select decode helper lives here so the top and any future users agree on it.
package lc4_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL     = 2'd0,
    OP_DIV     = 2'd1,
    OP_MOD     = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  localparam logic [3:0] OPC_ARITH = 4'b0001;
  localparam logic [3:0] OPC_MOD   = 4'b1010;
  localparam logic [2:0] SUB_MUL   = 3'b001;
  localparam logic [2:0] SUB_DIV   = 3'b011;
  localparam logic [1:0] SUB_MOD   = 2'b11;

  function automatic op_t decode_op(input logic [15:0] insn, input logic mul_en);
    op_t op;
    op = OP_ILLEGAL;
    if (insn[15:12] == OPC_ARITH && insn[5:3] == SUB_MUL && mul_en) op = OP_MUL;
    else if (insn[15:12] == OPC_ARITH && insn[5:3] == SUB_DIV)      op = OP_DIV;
    else if (insn[15:12] == OPC_MOD && insn[5:4] == SUB_MOD)        op = OP_MOD;
    return op;
  endfunction

endpackage

// File: rtl/lc4_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module lc4_divstep #(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE:0]   rem_in,
  input  logic                 dividend_bit,
  input  logic [WORD_SIZE-1:0] divisor,
  output logic                 q_bit,
  output logic [WORD_SIZE:0]   rem_out
);

  logic [WORD_SIZE+1:0] shifted;
  logic [WORD_SIZE+1:0] dvs;

  assign shifted = {rem_in, dividend_bit};
  assign dvs     = {2'b00, divisor};
  assign q_bit   = (shifted >= dvs);
  assign rem_out = q_bit ? (WORD_SIZE+1)'(shifted - dvs) : shifted[WORD_SIZE:0];

endmodule

// File: rtl/lc4_muldiv.sv
// Iterative unsigned MUL/DIV/MOD unit for LC4 with valid/ready handshakes on
// both request and result sides; one bit of work per clock in CALC.
module lc4_muldiv
  import lc4_muldiv_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int MUL_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [15:0]          i_insn,
  input  logic [WORD_SIZE-1:0] i_r1data,
  input  logic [WORD_SIZE-1:0] i_r2data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_divzero,
  output logic                 o_illegal
);

  localparam int CNT_W = $clog2(WORD_SIZE + 1);

  state_t               state, state_nxt;
  op_t                  op_q, op_dec;
  logic [CNT_W-1:0]     count;
  logic [WORD_SIZE-1:0] a_q, b_q, acc_q, result_q;
  logic [WORD_SIZE-1:0] acc_nxt, quo_nxt;
  logic [WORD_SIZE:0]   rem_q, rem_nxt;
  logic                 q_bit, divzero_q, illegal_q;
  logic                 skip, last_iter;

  assign op_dec    = decode_op(i_insn, MUL_EN != 0);
  // Illegal ops and divide-by-zero have a fixed answer, so they bypass CALC.
  assign skip      = (op_dec == OP_ILLEGAL) || (op_dec != OP_MUL && i_r2data == '0);
  assign last_iter = (count == CNT_W'(1));
  assign acc_nxt   = b_q[0] ? acc_q + a_q : acc_q;
  assign quo_nxt   = {a_q[WORD_SIZE-2:0], q_bit};

  // a_q doubles as the dividend shift register; quotient bits fill it from the LSB.
  lc4_divstep #(.WORD_SIZE(WORD_SIZE)) u_divstep (
    .rem_in       (rem_q),
    .dividend_bit (a_q[WORD_SIZE-1]),
    .divisor      (b_q),
    .q_bit        (q_bit),
    .rem_out      (rem_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = skip ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath is reset as well, because reset must clear the result
  // outputs and the counter even when it lands in the middle of CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ILLEGAL;
      count     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      divzero_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          op_q      <= op_dec;
          a_q       <= i_r1data;
          b_q       <= i_r2data;
          acc_q     <= '0;
          rem_q     <= '0;
          count     <= skip ? '0 : CNT_W'(WORD_SIZE);
          result_q  <= '0;
          divzero_q <= skip && (op_dec != OP_ILLEGAL);
          illegal_q <= (op_dec == OP_ILLEGAL);
        end
        CALC: begin
          count <= count - CNT_W'(1);
          if (op_q == OP_MUL) begin
            acc_q <= acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            rem_q <= rem_nxt;
            a_q   <= quo_nxt;
          end
          if (last_iter) begin
            case (op_q)
              OP_MUL:  result_q <= acc_nxt;
              OP_DIV:  result_q <= quo_nxt;
              default: result_q <= rem_nxt[WORD_SIZE-1:0];
            endcase
          end
        end
        DONE: if (i_ready) begin
          result_q  <= '0;
          divzero_q <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (state == IDLE);
  assign o_valid   = (state == DONE);
  assign o_result  = result_q;
  assign o_divzero = divzero_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_lc4_muldiv.sv
// Randomised and directed bench for lc4_muldiv at WORD_SIZE 16 and 8, checked
// against an arithmetic reference model of the instruction semantics.
module tb_lc4_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v16 = 1'b0, rdy16 = 1'b0;
  logic [15:0] insn16 = '0, a16 = '0, b16 = '0;
  logic        o_ready16, o_valid16, dz16, ill16;
  logic [15:0] res16;

  logic        v8 = 1'b0, rdy8 = 1'b0;
  logic [15:0] insn8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        o_ready8, o_valid8, dz8, ill8;
  logic [7:0]  res8;

  int passed = 0;
  int total  = 0;

  lc4_muldiv #(.WORD_SIZE(16), .MUL_EN(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_valid(v16), .o_ready(o_ready16), .i_insn(insn16),
    .i_r1data(a16), .i_r2data(b16), .o_valid(o_valid16), .i_ready(rdy16),
    .o_result(res16), .o_divzero(dz16), .o_illegal(ill16));

  lc4_muldiv #(.WORD_SIZE(8), .MUL_EN(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_valid(v8), .o_ready(o_ready8), .i_insn(insn8),
    .i_r1data(a8), .i_r2data(b8), .o_valid(o_valid8), .i_ready(rdy8),
    .o_result(res8), .o_divzero(dz8), .o_illegal(ill8));

  typedef struct packed {
    logic [63:0] res;
    logic        dz;
    logic        ill;
    logic [7:0]  lat;
  } exp_t;

  // Reference semantics: plain unsigned arithmetic, truncated to w bits.
  function automatic exp_t model(input int w, input logic [15:0] insn,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] mask;
    bit is_mul, is_div, is_mod;
    mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    is_mul = (insn[15:12] == 4'b0001) && (insn[5:3] == 3'b001);
    is_div = (insn[15:12] == 4'b0001) && (insn[5:3] == 3'b011);
    is_mod = (insn[15:12] == 4'b1010) && (insn[5:4] == 2'b11);
    e = '0;
    if (is_mul) begin
      e.res = (a * b) & mask;
      e.lat = 8'(w + 1);
    end else if (is_div || is_mod) begin
      if (b == 0) begin
        e.dz  = 1'b1;
        e.lat = 8'd1;
      end else begin
        e.res = is_div ? (a / b) : (a % b);
        e.lat = 8'(w + 1);
      end
    end else begin
      e.ill = 1'b1;
      e.lat = 8'd1;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_insn(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0:       return {4'b0001, r[5:0], 3'b001, r[8:6]};
      1:       return {4'b0001, r[5:0], 3'b011, r[8:6]};
      2:       return {4'b1010, r[5:0], 2'b11, r[9:6]};
      default: return r[15:0];
    endcase
  endfunction

  // Called at a negedge; presents the request for one cycle, then scrambles the
  // inputs so any failure to latch on accept shows up in the result.
  task automatic start16(input logic [15:0] insn, input logic [15:0] a, input logic [15:0] b);
    v16 = 1'b1; insn16 = insn; a16 = a; b16 = b;
    @(negedge clk);
    v16 = 1'b0; insn16 = 16'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic wait16(output int lat);
    lat = 1;
    while (o_valid16 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release16;
    rdy16 = 1'b1;
    @(negedge clk);
    rdy16 = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({o_valid16, dz16, ill16, res16} !== 19'd0)
      $display("FAIL reset_outputs: got v=%b dz=%b ill=%b res=%h want all zero",
               o_valid16, dz16, ill16, res16);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (o_ready16 !== 1'b1 || o_ready8 !== 1'b1)
      $display("FAIL reset_ready: got %b/%b want 1/1", o_ready16, o_ready8);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] t_insn[7] = '{16'h1008, 16'h1008, 16'h1018, 16'hA030, 16'h1018, 16'h1018, 16'h1000};
    logic [15:0] t_a[7]    = '{16'd3, 16'hFFFF, 16'd100, 16'd100, 16'hFFFF, 16'd42, 16'd5};
    logic [15:0] t_b[7]    = '{16'd5, 16'hFFFF, 16'd7, 16'd7, 16'd1, 16'd0, 16'd6};
    logic [15:0] t_res[7]  = '{16'h000F, 16'h0001, 16'h000E, 16'h0002, 16'hFFFF, 16'h0000, 16'h0000};
    logic        t_dz[7]   = '{0, 0, 0, 0, 0, 1, 0};
    logic        t_ill[7]  = '{0, 0, 0, 0, 0, 0, 1};
    int          t_lat[7]  = '{17, 17, 17, 17, 17, 1, 1};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start16(t_insn[i], t_a[i], t_b[i]);
      if (t_lat[i] > 1) begin
        total++;
        if (o_valid16 !== 1'b0 || dz16 !== 1'b0 || ill16 !== 1'b0)
          $display("FAIL dir%0d_calc_flags: got v=%b dz=%b ill=%b want 0", i, o_valid16, dz16, ill16);
        else passed++;
      end
      wait16(lat);
      total++;
      if (lat !== t_lat[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, t_lat[i]);
      else passed++;
      total++;
      if ({res16, dz16, ill16} !== {t_res[i], t_dz[i], t_ill[i]})
        $display("FAIL dir%0d_result: got %h dz=%b ill=%b want %h dz=%b ill=%b",
                 i, res16, dz16, ill16, t_res[i], t_dz[i], t_ill[i]);
      else passed++;
      release16();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start16(16'h1008, 16'd7, 16'd9);
    wait16(lat);
    total++;
    if (lat !== 17) $display("FAIL bp_latency: got %0d want 17", lat);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      // A competing request during DONE must be ignored.
      v16 = 1'b1; insn16 = 16'h1018; a16 = 16'd1; b16 = 16'd1;
      @(negedge clk);
      total++;
      if (res16 !== 16'h003F || o_ready16 !== 1'b0 || o_valid16 !== 1'b1 || dz16 !== 1'b0)
        $display("FAIL bp_hold%0d: got res=%h rdy=%b v=%b want res=003f rdy=0 v=1",
                 c, res16, o_ready16, o_valid16);
      else passed++;
    end
    v16 = 1'b0;
    release16();
  endtask

  task automatic test_back_to_back;
    int lat;
    rdy16 = 1'b1;
    start16(16'h1008, 16'd7, 16'd9);
    wait16(lat);
    total++;
    if (lat !== 17 || res16 !== 16'h003F || o_ready16 !== 1'b0)
      $display("FAIL b2b_first: got lat=%0d res=%h rdy=%b want 17 003f 0", lat, res16, o_ready16);
    else passed++;
    @(negedge clk);
    rdy16 = 1'b0;
    total++;
    if (o_ready16 !== 1'b1 || o_valid16 !== 1'b0 || res16 !== 16'h0000)
      $display("FAIL b2b_ready: got rdy=%b v=%b res=%h want 1 0 0000", o_ready16, o_valid16, res16);
    else passed++;
    start16(16'h1018, 16'd9, 16'd3);
    wait16(lat);
    total++;
    if (lat !== 17 || res16 !== 16'h0003)
      $display("FAIL b2b_second: got lat=%0d res=%h want 17 0003", lat, res16);
    else passed++;
    release16();
  endtask

  task automatic test_reset_midcalc;
    int lat;
    int seen;
    start16(16'h1018, 16'd1000, 16'd7);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_valid16, dz16, ill16, res16} !== 19'd0)
      $display("FAIL rst_mid_outputs: got v=%b dz=%b ill=%b res=%h want all zero",
               o_valid16, dz16, ill16, res16);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (o_valid16 === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0 || o_ready16 !== 1'b1)
      $display("FAIL rst_mid_discard: got %0d valid cycles rdy=%b want 0 and 1", seen, o_ready16);
    else passed++;
    start16(16'h1018, 16'd9, 16'd3);
    wait16(lat);
    total++;
    if (lat !== 17 || res16 !== 16'h0003)
      $display("FAIL rst_mid_next: got lat=%0d res=%h want 17 0003", lat, res16);
    else passed++;
    release16();
  endtask

  task automatic test_random;
    int lat;
    exp_t e;
    logic [15:0] insn, a, b;
    for (int i = 0; i < 40; i++) begin
      insn = rand_insn($urandom_range(0, 3));
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      e = model(16, insn, 64'(a), 64'(b));
      start16(insn, a, b);
      wait16(lat);
      total++;
      if (lat !== int'(e.lat) || {res16, dz16, ill16} !== {e.res[15:0], e.dz, e.ill})
        $display("FAIL rnd%0d insn=%h a=%h b=%h: got lat=%0d res=%h dz=%b ill=%b want lat=%0d res=%h dz=%b ill=%b",
                 i, insn, a, b, lat, res16, dz16, ill16, e.lat, e.res[15:0], e.dz, e.ill);
      else passed++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release16();
    end
  endtask

  task automatic test_w8;
    int lat;
    exp_t e;
    logic [15:0] insn;
    logic [7:0]  a, b;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        insn = 16'h1008; a = 8'h10; b = 8'h10;
      end else begin
        insn = rand_insn($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
      end
      e = model(8, insn, 64'(a), 64'(b));
      v8 = 1'b1; insn8 = insn; a8 = a; b8 = b;
      @(negedge clk);
      v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (o_valid8 !== 1'b1 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      total++;
      if (lat !== int'(e.lat) || {res8, dz8, ill8} !== {e.res[7:0], e.dz, e.ill})
        $display("FAIL w8_%0d insn=%h a=%h b=%h: got lat=%0d res=%h dz=%b ill=%b want lat=%0d res=%h dz=%b ill=%b",
                 i, insn, a, b, lat, res8, dz8, ill8, e.lat, e.res[7:0], e.dz, e.ill);
      else passed++;
      rdy8 = 1'b1;
      @(negedge clk);
      rdy8 = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midcalc();
    test_random();
    test_w8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
